rtl_divider_core: RTL and testbench
===================================

# rtl_divider_core

Iterative radix-2 restoring divider that computes quotient and remainder of two DATA_WIDTH operands, signed or unsigned, with valid/ready handshakes on both sides. It sits directly behind the rtl_divider AXI4-Lite register bank. The bank forwards dividend and divisor, launches a division through the input handshake, and captures quotient, remainder and status from the output handshake into its readable registers.

## Interface
- DATA_WIDTH, 32, operand/result width in bits (≥ 2).
- CNT_W, $clog2(DATA_WIDTH)+1, iteration counter width (derived, not overridden).

Ports (clock and reset first):
- ACLK  in  1  system clock; all state updates on rising edge.
- ARESET  in  1  reset. One clock; reset is asynchronous and active-high.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  core idle and able to accept.
- in_signed  in  1  1 = two's-complement division, 0 = unsigned; sampled on accept.
- dividend  in  DATA_WIDTH  numerator; sampled on accept.
- divisor  in  DATA_WIDTH  denominator; sampled on accept.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- quotient  out  DATA_WIDTH  result quotient.
- remainder  out  DATA_WIDTH  result remainder.
- div_by_zero  out  1  divisor was zero for this result.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. in_valid & in_ready at an edge is an accept, and latches:
  - magnitudes |dividend| and |divisor|. Signed mode only: negate when MSB=1.
  - q_neg = sign(dividend)^sign(divisor); r_neg = sign(dividend); both forced 0 in unsigned mode.
  - dbz = (divisor==0); count=0.
  - Next state CALC.
- CALC: one restoring step per cycle, MSB first.
  - Shift {rem, quo} left by 1 with the next dividend bit entering rem LSB.
  - Compute trial = rem − divisor_mag on DATA_WIDTH+1 bits.
  - If trial is non-negative: rem=trial, quo LSB=1. Otherwise rem is unchanged and quo LSB=0.
  - count increments. After the step with count==DATA_WIDTH−1, go to FIX.
- FIX: registers the outputs.
  - quotient = q_neg ? −quo : quo; remainder = r_neg ? −rem : rem. Results are truncated to DATA_WIDTH with wrap.
  - If dbz: quotient = all ones, remainder = original dividend (raw bits), div_by_zero=1.
  - Next state DONE.
- DONE: out_valid=1, and quotient, remainder and div_by_zero are held stable. out_valid & out_ready moves to IDLE.
- Signed overflow case, most-negative ÷ −1: the quotient wraps to most-negative and the remainder is 0. No flag is raised.
- Remainder sign follows the dividend (truncating division). |remainder| < |divisor| always holds when the divisor is non-zero.

## Timing
- Reset values (asynchronous on ARESET high, held while high):
  - state=IDLE, in_ready=1, busy=0.
  - out_valid=0, div_by_zero=0, quotient=0, remainder=0, internal registers 0.
  - An accept is never taken while ARESET=1.
- Fixed latency:
  - Accept at edge E0, CALC steps at E1..E_DATA_WIDTH, FIX at E_DATA_WIDTH+1.
  - out_valid is high from E_DATA_WIDTH+1, i.e. DATA_WIDTH+1 cycles after accept (33 for DATA_WIDTH=32).
  - Latency is identical for divide-by-zero and for every operand value.
- in_ready=0 from E0 until the output handshake edge. in_valid is ignored during that time.
- Output handshake at edge Ek gives in_ready=1 from Ek.
  - The earliest new accept is Ek+1. Throughput is one result per DATA_WIDTH+3 cycles with out_ready tied high.
- out_ready low in DONE: all outputs are held indefinitely.
- out_ready high outside DONE has no effect.
- ARESET asserted mid-CALC, FIX or DONE: the in-flight result is discarded and no out_valid pulse occurs. The core returns to the reset values immediately.
- Input operand changes after accept do not affect the in-flight result.

## Test plan
- Unsigned 100 ÷ 7, out_ready=1: out_valid rises exactly 33 cycles after accept with quotient=14, remainder=2, div_by_zero=0. out_valid stays high for one cycle.
- Signed −7 ÷ 2: quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Signed 7 ÷ −2 gives quotient=0xFFFFFFFD, remainder=0x00000001.
- Divide by zero, 5 ÷ 0 in both modes: quotient=0xFFFFFFFF, remainder=0x00000005, div_by_zero=1, latency still 33.
- Signed 0x80000000 ÷ 0xFFFFFFFF: quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF ÷ 1 gives quotient=0xFFFFFFFF, remainder=0.
- Backpressure with out_ready=0 for 10 cycles in DONE:
  - outputs are stable, in_ready=0, and a second in_valid with 9 ÷ 3 is not accepted;
  - after out_ready=1 the core accepts 9 ÷ 3 one cycle later, giving quotient=3, remainder=0.
- ARESET pulsed 10 cycles into CALC:
  - all outputs read their reset values during the pulse and out_valid never asserts for that operation;
  - after release, 50 ÷ 8 completes normally with quotient=6, remainder=2.

Source files
------------

// File: rtl/rtl_divider_core_if.sv
// Handshake bundle between the divider register bank and the core.
// Operands/mode in on one valid/ready pair, results out on the other.
interface rtl_divider_core_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_signed;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;
  logic                  busy;

  modport master (
    output in_valid,
    output in_signed,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_signed,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero,
    output busy
  );

endinterface

// File: rtl/rtl_divider_core.sv
// Iterative radix-2 restoring divider, signed or unsigned.
// Fixed DATA_WIDTH+1 cycle latency from accept to out_valid.
module rtl_divider_core #(
  parameter int DATA_WIDTH = 32
) (
  input logic              ACLK,
  input logic              ARESET,
  rtl_divider_core_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int W     = DATA_WIDTH;

  localparam logic [W-1:0]     ONE  = W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     dmag_q, dmag_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     remo_q, remo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic             dbzo_q, dbzo_d;

  logic [W:0] shifted;
  logic [W:0] trial;
  logic       dvd_neg;
  logic       dsr_neg;

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dmag_d  = dmag_q;
    dvd_d   = dvd_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dbz_d   = dbz_q;
    dbzo_d  = dbzo_q;

    dvd_neg = bus.in_signed & bus.dividend[W-1];
    dsr_neg = bus.in_signed & bus.divisor[W-1];

    // Remainder gains the next dividend bit; MSB of trial is the borrow.
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, dmag_q};

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          quo_d   = dvd_neg ? (~bus.dividend + ONE)
                            : bus.dividend;
          dmag_d  = dsr_neg ? (~bus.divisor + ONE)
                            : bus.divisor;
          dvd_d   = bus.dividend;
          rem_d   = '0;
          q_neg_d = dvd_neg ^ dsr_neg;
          r_neg_d = dvd_neg;
          dbz_d   = (bus.divisor == '0);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!trial[W]) begin
          rem_d = trial[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = shifted[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CONE;
        if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dbz_q) begin
          quot_d = '1;
          remo_d = dvd_q;
          dbzo_d = 1'b1;
        end else begin
          quot_d = q_neg_q ? (~quo_q + ONE) : quo_q;
          remo_d = r_neg_q ? (~rem_q + ONE) : rem_q;
          dbzo_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dmag_q  <= '0;
      dvd_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
      dbzo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dmag_q  <= dmag_d;
      dvd_q   <= dvd_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_q   <= dbz_d;
      dbzo_q  <= dbzo_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbzo_q;

endmodule

// File: tb/tb_rtl_divider_core.sv
// Randomized bench for rtl_divider_core against an arithmetic model.
// Also covers latency, backpressure and mid-operation reset.
module tb_rtl_divider_core;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic ACLK;
  logic ARESET;

  int n_tests = 0;
  int n_fail  = 0;

  rtl_divider_core_if #(.DATA_WIDTH(W)) bus ();

  rtl_divider_core #(.DATA_WIDTH(W)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus.slave)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // Truncating division from plain integer arithmetic.
  task automatic ref_div(
    input  bit          sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r,
    output bit          z
  );
    longint sa, sb;
    z = (b == 0);
    if (z) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic launch(
    input bit          sgn,
    input logic [31:0] a,
    input logic [31:0] b
  );
    bus.in_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    bus.in_signed = 1'($urandom);
  endtask

  task automatic run_div(
    input string       tag,
    input bit          sgn,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          hold
  );
    logic [31:0] eq, er;
    bit ez, stable;
    int cyc;
    ref_div(sgn, a, b, eq, er, ez);
    bus.out_ready = (hold == 0);
    launch(sgn, a, b);
    chk({tag, ".busy"}, bus.busy, 1);
    wait_valid(cyc);
    chk({tag, ".lat"}, cyc, LAT);
    chk({tag, ".q"}, bus.quotient, eq);
    chk({tag, ".r"}, bus.remainder, er);
    chk({tag, ".dbz"}, bus.div_by_zero, ez);
    if (hold > 0) begin
      stable = 1;
      repeat (hold) begin
        tick();
        if (!bus.out_valid || bus.in_ready ||
            bus.quotient !== eq ||
            bus.remainder !== er)
          stable = 0;
      end
      chk({tag, ".hold"}, stable, 1);
      bus.out_ready = 1'b1;
    end
    tick();
    chk({tag, ".pulse"}, bus.out_valid, 0);
    chk({tag, ".rdy"}, bus.in_ready, 1);
  endtask

  initial begin
    int cyc;
    bit stable, seen;
    logic [31:0] a, b, q0, r0;
    bit sgn;
    int hold;

    ARESET        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst.rdy", bus.in_ready, 1);
    chk("rst.busy", bus.busy, 0);
    chk("rst.vld", bus.out_valid, 0);
    chk("rst.q", bus.quotient, 0);
    chk("rst.r", bus.remainder, 0);
    chk("rst.dbz", bus.div_by_zero, 0);
    ARESET = 1'b0;
    tick();

    run_div("u100_7", 0, 100, 7, 0);
    run_div("s-7_2", 1, -32'sd7, 2, 0);
    run_div("s7_-2", 1, 7, -32'sd2, 0);
    run_div("u5_0", 0, 5, 0, 0);
    run_div("s5_0", 1, 5, 0, 0);
    run_div("sovf", 1, 32'h8000_0000,
            32'hFFFF_FFFF, 0);
    run_div("umax_1", 0, 32'hFFFF_FFFF, 1, 0);

    // Backpressure with a queued second request.
    bus.out_ready = 1'b0;
    launch(0, 200, 9);
    wait_valid(cyc);
    chk("bp.lat", cyc, LAT);
    chk("bp.q", bus.quotient, 22);
    chk("bp.r", bus.remainder, 2);
    q0 = bus.quotient;
    r0 = bus.remainder;
    bus.in_signed = 1'b0;
    bus.dividend  = 9;
    bus.divisor   = 3;
    bus.in_valid  = 1'b1;
    stable = 1;
    repeat (10) begin
      tick();
      if (!bus.out_valid || bus.in_ready ||
          bus.quotient !== q0 ||
          bus.remainder !== r0)
        stable = 0;
    end
    chk("bp.hold", stable, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp.hs_rdy", bus.in_ready, 1);
    chk("bp.hs_vld", bus.out_valid, 0);
    tick();
    chk("bp.acc", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    chk("bp2.lat", cyc, LAT);
    chk("bp2.q", bus.quotient, 3);
    chk("bp2.r", bus.remainder, 0);
    tick();

    // Reset during CALC discards the operation.
    launch(0, 1000, 3);
    repeat (10) tick();
    ARESET = 1'b1;
    #1;
    chk("mr.rdy", bus.in_ready, 1);
    chk("mr.busy", bus.busy, 0);
    chk("mr.vld", bus.out_valid, 0);
    chk("mr.q", bus.quotient, 0);
    chk("mr.r", bus.remainder, 0);
    bus.dividend = 4;
    bus.divisor  = 2;
    bus.in_valid = 1'b1;
    tick();
    tick();
    chk("mr.noacc", bus.busy, 0);
    ARESET = 1'b0;
    bus.in_valid = 1'b0;
    seen = 0;
    repeat (45) begin
      tick();
      if (bus.out_valid) seen = 1;
    end
    chk("mr.nopulse", seen, 0);
    run_div("u50_8", 0, 50, 8, 0);

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      a = $urandom;
      if ($urandom_range(0, 7) == 0)
        a = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        default: b = -$urandom_range(1, 15);
      endcase
      hold = $urandom_range(0, 2);
      run_div($sformatf("rnd%0d", i),
              sgn, a, b, hold);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
